// File: rtl/wb_pkg.sv
// Shared types and defaults for the Wishbone single-cycle master.
package wb_pkg;

   localparam int WB_ADDR_WIDTH     = 8;
   localparam int WB_DATA_WIDTH     = 8;
   localparam int WB_TIMEOUT_CYCLES = 16;

   typedef enum logic [1:0] {WB_IDLE, WB_BUS, WB_RESP} wb_mst_state_t;

   // A 1-bit floor keeps the counter legal when $clog2 would return 0.
   function automatic int timer_width(input int cycles);
      return (cycles < 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/wb_timeout_timer.sv
// Clear/enable up-counter that flags when it reaches LIMIT-1.
module wb_timeout_timer #(
   parameter int LIMIT = 16,
   parameter int WIDTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic done
);

   logic [WIDTH-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         count <= '0;
      else if (clear)  count <= '0;
      else if (enable) count <= count + 1'b1;
   end

   assign done = (count == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/wb_single_master.sv
// Wishbone classic master: one CYC/STB cycle per accepted command, ACK or timeout.
module wb_single_master
   import wb_pkg::*;
#(
   parameter int ADDR_WIDTH     = WB_ADDR_WIDTH,
   parameter int DATA_WIDTH     = WB_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_we_i,
   input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
   input  logic [DATA_WIDTH-1:0] cmd_dat_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_dat_o,
   output logic                  rsp_timeout_o,
   output logic [ADDR_WIDTH-1:0] adr_o,
   output logic [DATA_WIDTH-1:0] dat_o,
   input  logic [DATA_WIDTH-1:0] dat_i,
   output logic                  we_o,
   output logic                  cyc_o,
   output logic                  stb_o,
   input  logic                  ack_i
);

   localparam int TIMER_WIDTH = timer_width(TIMEOUT_CYCLES);

   wb_mst_state_t state, state_next;
   logic cmd_fire, ack_done, timeout_done, rsp_fire;
   logic timer_done;

   assign cmd_ready_o = (state == WB_IDLE);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= WB_IDLE;
      else       state <= state_next;
   end

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_next   = state;
      cmd_fire     = 1'b0;
      ack_done     = 1'b0;
      timeout_done = 1'b0;
      rsp_fire     = 1'b0;
      case (state)
         WB_IDLE: if (cmd_valid_i) begin
            cmd_fire   = 1'b1;
            state_next = WB_BUS;
         end
         WB_BUS: if (ack_i) begin
            ack_done   = 1'b1;
            state_next = WB_RESP;
         end else if (timer_done) begin
            timeout_done = 1'b1;
            state_next   = WB_RESP;
         end
         WB_RESP: if (rsp_ready_i) begin
            rsp_fire   = 1'b1;
            state_next = WB_IDLE;
         end
         default: state_next = WB_IDLE;
      endcase
   end

   // Timer sits at zero outside BUS so each bus cycle starts a fresh count.
   wb_timeout_timer #(
      .LIMIT (TIMEOUT_CYCLES),
      .WIDTH (TIMER_WIDTH)
   ) u_timer (
      .clk    (clk_i),
      .rst    (rst_i),
      .clear  (state != WB_BUS),
      .enable ((state == WB_BUS) && !ack_i),
      .done   (timer_done)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         adr_o         <= '0;
         dat_o         <= '0;
         we_o          <= 1'b0;
         cyc_o         <= 1'b0;
         stb_o         <= 1'b0;
         rsp_valid_o   <= 1'b0;
         rsp_dat_o     <= '0;
         rsp_timeout_o <= 1'b0;
      end else begin
         if (cmd_fire) begin
            adr_o <= cmd_adr_i;
            dat_o <= cmd_we_i ? cmd_dat_i : '0;
            we_o  <= cmd_we_i;
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
         end
         // we_o is still the latched direction on the completing edge.
         if (ack_done || timeout_done) begin
            dat_o         <= '0;
            we_o          <= 1'b0;
            cyc_o         <= 1'b0;
            stb_o         <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_timeout_o <= timeout_done;
            rsp_dat_o     <= (ack_done && !we_o) ? dat_i : '0;
         end
         if (rsp_fire) rsp_valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_single_master.sv
// Directed bench for wb_single_master with a behavioural register slave and a response scoreboard.
module tb_wb_single_master;
   import wb_pkg::*;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_we = 1'b0;
   logic [AW-1:0] cmd_adr = '0;
   logic [DW-1:0] cmd_dat = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [DW-1:0] rsp_dat;
   logic          rsp_timeout;
   logic [AW-1:0] adr;
   logic [DW-1:0] dat_w;
   logic [DW-1:0] dat_r;
   logic          we, cyc, stb, ack;

   always #5 clk = ~clk;

   wb_single_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk), .rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
      .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
      .rsp_timeout_o(rsp_timeout),
      .adr_o(adr), .dat_o(dat_w), .dat_i(dat_r), .we_o(we),
      .cyc_o(cyc), .stb_o(stb), .ack_i(ack)
   );

   // Register slave: combinational ACK after ack_delay wait cycles when enabled.
   logic [DW-1:0] mem [256] = '{default: 8'h00};
   logic          ack_en = 1'b1;
   logic          ack_extra = 1'b0;
   int            ack_delay = 0;
   int            wait_cnt = 0;
   logic          slave_ack;

   assign slave_ack = cyc && stb && ack_en && (wait_cnt >= ack_delay);
   assign ack       = slave_ack || ack_extra;
   assign dat_r     = mem[adr];

   always @(posedge clk) begin
      if (!cyc)            wait_cnt <= 0;
      else if (!slave_ack) wait_cnt <= wait_cnt + 1;
      if (cyc && stb && we && slave_ack) mem[adr] <= dat_w;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: stimulus pushes expected responses, monitor pops on handshake.
   typedef struct {
      logic [DW-1:0] dat;
      logic          to;
   } exp_t;
   exp_t sb[$];

   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_rsp", 32'(rsp_valid), 32'h0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rsp_dat", 32'(rsp_dat), 32'(e.dat));
            check("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
         end
      end
   end

   // Bus monitor: cycle length, direction, inter-transaction gap, idle-bus hygiene.
   int   cyc_starts = 0;
   int   cur_len = 0, last_len = 0;
   int   gap = 1000, min_gap = 1000;
   logic cur_we = 1'b0, last_we = 1'b0, cyc_prev = 1'b0;

   always @(negedge clk) begin
      if (cyc) begin
         if (!cyc_prev) begin
            cyc_starts++;
            if (gap < min_gap) min_gap = gap;
            cur_len = 0;
            cur_we  = 1'b0;
         end
         cur_len++;
         if (we) cur_we = 1'b1;
      end else begin
         if (cyc_prev) begin
            last_len = cur_len;
            last_we  = cur_we;
            gap      = 0;
         end
         gap++;
      end
      cyc_prev = cyc;
      if (!rst && (cyc || stb)) check("stb_eq_cyc", 32'(stb), 32'(cyc));
      if (!rst && !cyc && (we || dat_w != '0)) check("idle_we_dat", {23'd0, we, dat_w}, 32'h0);
   end

   task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] exp_dat, input logic exp_to);
      exp_t e;
      int   t = 0;
      e.dat = exp_dat;
      e.to  = exp_to;
      sb.push_back(e);
      cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_valid = 1'b1;
      while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) check("cmd_accept_wait", 32'(cmd_ready), 32'h1);
      @(posedge clk); #1;
      // Garbage after acceptance must not reach the bus.
      cmd_valid = 1'b0; cmd_we = ~w; cmd_adr = a ^ 8'hFF; cmd_dat = 8'h5C;
   endtask

   task automatic drain();
      int t = 0;
      while ((sb.size() != 0 || rsp_valid || cyc) && t < 300) begin @(negedge clk); t++; end
      if (t >= 300) check("drain_wait", 32'(sb.size()), 32'h0);
      @(negedge clk);
   endtask

   initial begin
      int   t;
      int   starts;

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_cyc", 32'(cyc), 32'h0);
      check("rst_stb", 32'(stb), 32'h0);
      check("rst_we", 32'(we), 32'h0);
      check("rst_adr_dat", {16'd0, adr, dat_w}, 32'h0);
      check("rst_rsp", {rsp_valid, rsp_timeout, 22'd0, rsp_dat}, 32'h0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'h1);

      // Read after reset, then write/read back with fastest ACK
      issue(1'b0, 8'h00, 8'h99, 8'h00, 1'b0);
      drain();
      check("read0_len", 32'(last_len), 32'd1);
      check("read0_we", 32'(last_we), 32'h0);
      issue(1'b1, 8'h00, 8'h73, 8'h00, 1'b0);
      drain();
      check("write_we", 32'(last_we), 32'h1);
      check("write_mem", 32'(mem[0]), 32'h73);
      issue(1'b0, 8'h00, 8'h00, 8'h73, 1'b0);
      drain();
      check("read73_we", 32'(last_we), 32'h0);
      issue(1'b1, 8'h5A, 8'hC3, 8'h00, 1'b0);
      issue(1'b1, 8'h10, 8'hAA, 8'h00, 1'b0);
      issue(1'b0, 8'h5A, 8'h11, 8'hC3, 1'b0);
      drain();

      // ACK arriving on the timeout edge completes normally
      ack_delay = TO - 1;
      issue(1'b0, 8'h10, 8'h00, 8'hAA, 1'b0);
      drain();
      check("late_ack_len", 32'(last_len), 32'(TO));

      // No ACK: abort after exactly TO cycles
      ack_en = 1'b0;
      issue(1'b0, 8'h10, 8'h00, 8'h00, 1'b1);
      drain();
      check("timeout_len", 32'(last_len), 32'(TO));
      ack_en = 1'b1;
      ack_delay = 0;

      // ACK outside BUS is ignored
      ack_extra = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("stray_ack_idle", {29'd0, rsp_valid, cyc, cmd_ready}, 32'h1);
      end
      ack_extra = 1'b0;

      // Response back-pressure
      rsp_ready = 1'b0;
      issue(1'b0, 8'h00, 8'h00, 8'h73, 1'b0);
      t = 0;
      while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
      starts = cyc_starts;
      repeat (5) begin
         @(negedge clk);
         check("stall_hold", {22'd0, rsp_valid, rsp_timeout, rsp_dat}, {22'd0, 1'b1, 1'b0, 8'h73});
         check("stall_bus", {30'd0, cmd_ready, cyc}, 32'h0);
      end
      check("stall_no_start", 32'(cyc_starts), 32'(starts));
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      drain();

      // Back-to-back commands keep a gap between cycles
      min_gap = 1000;
      starts  = cyc_starts;
      issue(1'b1, 8'h21, 8'h01, 8'h00, 1'b0);
      issue(1'b1, 8'h22, 8'h02, 8'h00, 1'b0);
      issue(1'b0, 8'h21, 8'h00, 8'h01, 1'b0);
      issue(1'b0, 8'h22, 8'h00, 8'h02, 1'b0);
      drain();
      check("b2b_count", 32'(cyc_starts - starts), 32'd4);
      check("b2b_gap_ok", 32'(min_gap >= 1), 32'h1);

      // Reset mid-BUS drops the cycle at once and loses the op
      ack_en = 1'b0;
      issue(1'b0, 8'h5A, 8'h00, 8'h00, 1'b1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_cyc_stb", {30'd0, cyc, stb}, 32'h0);
      check("midrst_rsp", 32'(rsp_valid), 32'h0);
      void'(sb.pop_back());
      ack_en = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 32'(cmd_ready), 32'h1);
      check("post_rst_rsp", 32'(rsp_valid), 32'h0);
      issue(1'b0, 8'h5A, 8'h00, 8'hC3, 1'b0);
      drain();
      check("sb_empty", 32'(sb.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
